pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter FLUSH_EXTRA, default 1: bubble cycles added after a taken jump, range 0..3.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port jump_en_i_exu_ctrl, input, 1: EXU resolved a taken branch or jump this cycle.
REQ-005 Port jump_addr_i_exu_ctrl, input, $clog2(`ROM_DEPTH): jump target.
REQ-006 Port stall_req_i_exu_ctrl, input, 1: EXU multi-cycle op busy; level, held until done.
REQ-007 Port hazard_i_idu_ctrl, input, 1: IDU load-use hazard; level.
REQ-008 Port jump_en_o_ctrl_pcu, output, 1: PC load strobe.
REQ-009 Port jump_addr_o_ctrl_pcu, output, $clog2(`ROM_DEPTH): PC load value.
REQ-010 Port pc_stall_o_ctrl_pcu, output, 1: PC freeze.
REQ-011 Port ifid_stall_o_ctrl_ifu2idu, output, 1: IF/ID freeze.
REQ-012 Port ifid_flush_o_ctrl_ifu2idu, output, 1: IF/ID load NOP.
REQ-013 Port hold_flag_o_ctrl_idu2exu, output, 1: ID/EX load NOP (`INSTR_NOP, zero operands, wen 0).
REQ-014 Port idex_stall_o_ctrl_idu2exu, output, 1: ID/EX freeze.
REQ-015 Ports stall_cnt_o, flush_cnt_o, outputs, 16 each: performance counters (see Configuration).

Function
REQ-016 States: RUN, FLUSH. FLUSH holds a 2-bit down-counter flush_cnt.
REQ-017 Priority, evaluated every cycle: jump > EXU stall > IDU hazard > FLUSH tail > idle.
REQ-018 Jump in cycle t passes combinationally: jump_en_o=1 and jump_addr_o=jump_addr_i in cycle t, with ifid_flush_o=1 and hold_flag_o=1 in cycle t.
REQ-019 Jump with FLUSH_EXTRA>0: next state FLUSH, flush_cnt=FLUSH_EXTRA-1. Jump with FLUSH_EXTRA=0: stay in RUN.
REQ-020 In FLUSH without a jump: ifid_flush_o=1, hold_flag_o=1, jump_en_o=0. Counter decrements each cycle; at 0, return to RUN next cycle.
REQ-021 FLUSH occupies exactly FLUSH_EXTRA cycles after the jump cycle.
REQ-022 Jump while in FLUSH restarts the sequence per REQ-018/019 with the new target.
REQ-023 EXU stall (no jump): pc_stall_o, ifid_stall_o and idex_stall_o all 1; no flush. Valid in either state; the FLUSH counter freezes during it.
REQ-024 IDU hazard (no jump, no EXU stall): pc_stall_o=1, ifid_stall_o=1, hold_flag_o=1 (one bubble per hazard cycle).
REQ-025 Stall and flush to the same register are never both 1; flush is suppressed when the matching stall is 1.
REQ-026 jump_addr_o is 0 when jump_en_o=0.
REQ-027 Jump together with a stall or hazard: jump wins; all stall outputs are 0 that cycle.

Reset
REQ-028 rst=1 forces asynchronously: state RUN, flush_cnt=0, counters=0, all flag outputs 0, jump_addr_o=0.
REQ-029 Reset during FLUSH or a stall aborts it; after release the first cycle is RUN.

Configuration
REQ-030 Macro CTRL_PERF_CNT_EN.
- Defined: stall_cnt_o counts cycles with pc_stall_o=1; flush_cnt_o counts cycles with hold_flag_o=1.
- Both counters are 16-bit, saturate at 16'hFFFF and clear only on reset.
REQ-031 Without CTRL_PERF_CNT_EN: both ports remain and are tied to 16'd0; no counter flops.

Structure
REQ-032 defines.v holds the state encodings (CTRL_RUN=1'b0, CTRL_FLUSH=1'b1) and the FLUSH_EXTRA maximum. Address width derives from `ROM_DEPTH.
REQ-033 Saturating counter is sub-module ctrl_sat_cnt (enable, 16-bit output), instantiated twice under the macro.

Verification
REQ-034 Jump pulse, jump_addr=12'h040, FLUSH_EXTRA=1:
- cycle t: jump_en_o=1, addr 12'h040, both flushes 1.
- t+1: both flushes 1.
- t+2: all flags 0.
REQ-035 stall_req high 5 cycles: pc/ifid/idex stalls 1 for exactly 5 cycles, no flushes; stall_cnt_o=5.
REQ-036 hazard high 1 cycle: pc_stall=1, ifid_stall=1, hold_flag=1 for 1 cycle; next cycle idle.
REQ-037 Jump (12'h010) at t, second jump (12'h020) at t+1, FLUSH_EXTRA=2:
- flushes 1 through t+3; jump_addr_o=12'h020 at t+1.
REQ-038 Jump and stall_req asserted together: jump outputs only, stalls 0; then stall_req still high -> stall next cycle.
REQ-039 rst pulsed mid-FLUSH: outputs 0 immediately (asynchronous); after release, RUN with counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
// ROM_DEPTH defaults to 4096 words (12-bit PC) unless the build supplies it.
`ifndef ROM_DEPTH
`define ROM_DEPTH 4096
`endif

package pipe_ctrl_pkg;
  localparam int ADDR_W          = $clog2(`ROM_DEPTH);
  localparam int FLUSH_EXTRA_MAX = 3;
  localparam int PERF_W          = 16;

  // RUN: normal issue; FLUSH: draining wrong-path instructions after a jump
  typedef enum logic {
    CTRL_RUN   = 1'b0,
    CTRL_FLUSH = 1'b1
  } ctrl_state_e;
endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating 16-bit event counter; cleared only by reset.
module ctrl_sat_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [PERF_W-1:0] cnt
);
  logic [PERF_W-1:0] cnt_reg;

  // Count enabled cycles, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + PERF_W'(1);
    end
  end

  assign cnt = cnt_reg;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: resolves jumps, EXU stalls and IDU load-use hazards into
// PC / IF-ID / ID-EX stall and flush controls, with FLUSH_EXTRA (0..3) bubble
// cycles after a taken jump.
// Optional macro CTRL_PERF_CNT_EN enables stall/bubble performance counters;
// without it stall_cnt_o and flush_cnt_o are constant zero.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_EXTRA = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en_i_exu_ctrl,
  input  logic [ADDR_W-1:0] jump_addr_i_exu_ctrl,
  input  logic              stall_req_i_exu_ctrl,
  input  logic              hazard_i_idu_ctrl,
  output logic              jump_en_o_ctrl_pcu,
  output logic [ADDR_W-1:0] jump_addr_o_ctrl_pcu,
  output logic              pc_stall_o_ctrl_pcu,
  output logic              ifid_stall_o_ctrl_ifu2idu,
  output logic              ifid_flush_o_ctrl_ifu2idu,
  output logic              hold_flag_o_ctrl_idu2exu,
  output logic              idex_stall_o_ctrl_idu2exu,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       flush_cnt_o
);
  // Counter value loaded on a jump so that FLUSH lasts exactly FLUSH_EXTRA cycles
  localparam logic [1:0] FLUSH_LOAD = (FLUSH_EXTRA > 0) ? 2'(FLUSH_EXTRA - 1) : 2'd0;

  ctrl_state_e state_reg, state_next;
  logic [1:0]  flush_cnt_reg, flush_cnt_next;

  logic jump_act;
  logic exu_act;
  logic haz_act;
  logic tail_act;

  // Priority decode: jump > EXU stall > IDU hazard > FLUSH tail; all quiet in reset
  assign jump_act = ~rst & jump_en_i_exu_ctrl;
  assign exu_act  = ~rst & ~jump_en_i_exu_ctrl & stall_req_i_exu_ctrl;
  assign haz_act  = ~rst & ~jump_en_i_exu_ctrl & ~stall_req_i_exu_ctrl & hazard_i_idu_ctrl;
  assign tail_act = ~rst & ~jump_en_i_exu_ctrl & ~stall_req_i_exu_ctrl & ~hazard_i_idu_ctrl
                  & (state_reg == CTRL_FLUSH);

  // State and flush down-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= CTRL_RUN;
      flush_cnt_reg <= 2'd0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  // Next state: a jump (re)starts the tail; stalls and hazards freeze it
  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    if (jump_act) begin
      if (FLUSH_EXTRA > 0) begin
        state_next     = CTRL_FLUSH;
        flush_cnt_next = FLUSH_LOAD;
      end else begin
        state_next     = CTRL_RUN;
        flush_cnt_next = 2'd0;
      end
    end else if (tail_act) begin
      if (flush_cnt_reg == 2'd0) begin
        state_next = CTRL_RUN;
      end else begin
        flush_cnt_next = flush_cnt_reg - 2'd1;
      end
    end
  end

  // Output decode; flushes only fire when the matching stage is not stalled
  always_comb begin
    jump_en_o_ctrl_pcu        = jump_act;
    jump_addr_o_ctrl_pcu      = jump_act ? jump_addr_i_exu_ctrl : '0;
    pc_stall_o_ctrl_pcu       = exu_act | haz_act;
    ifid_stall_o_ctrl_ifu2idu = exu_act | haz_act;
    idex_stall_o_ctrl_idu2exu = exu_act;
    ifid_flush_o_ctrl_ifu2idu = jump_act | tail_act;
    hold_flag_o_ctrl_idu2exu  = jump_act | haz_act | tail_act;
  end

`ifdef CTRL_PERF_CNT_EN
  ctrl_sat_cnt u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (pc_stall_o_ctrl_pcu),
    .cnt (stall_cnt_o)
  );

  ctrl_sat_cnt u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (hold_flag_o_ctrl_idu2exu),
    .cnt (flush_cnt_o)
  );
`else
  assign stall_cnt_o = 16'd0;
  assign flush_cnt_o = 16'd0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (FLUSH_EXTRA=1 and 2) share
// stimulus; a per-cycle reference model pushes expectations, a negedge
// monitor pops and compares.
`timescale 1ns/1ps
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic              jump_en;
    logic [ADDR_W-1:0] addr;
    logic              pc_stall;
    logic              ifid_stall;
    logic              ifid_flush;
    logic              hold;
    logic              idex_stall;
    logic [15:0]       scnt;
    logic [15:0]       fcnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              je  = 1'b0;
  logic              st  = 1'b0;
  logic              hz  = 1'b0;
  logic [ADDR_W-1:0] ja  = '0;

  logic              jen0, pcs0, ifs0, iff0, hld0, ixs0;
  logic              jen1, pcs1, ifs1, iff1, hld1, ixs1;
  logic [ADDR_W-1:0] adr0, adr1;
  logic [15:0]       sc0, fc0, sc1, fc1;

  exp_t q0[$];
  exp_t q1[$];
  int   rem[2];
  int   mscnt[2];
  int   mfcnt[2];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_EXTRA(1)) u_dut_fe1 (
    .clk(clk), .rst(rst),
    .jump_en_i_exu_ctrl(je), .jump_addr_i_exu_ctrl(ja),
    .stall_req_i_exu_ctrl(st), .hazard_i_idu_ctrl(hz),
    .jump_en_o_ctrl_pcu(jen0), .jump_addr_o_ctrl_pcu(adr0),
    .pc_stall_o_ctrl_pcu(pcs0), .ifid_stall_o_ctrl_ifu2idu(ifs0),
    .ifid_flush_o_ctrl_ifu2idu(iff0), .hold_flag_o_ctrl_idu2exu(hld0),
    .idex_stall_o_ctrl_idu2exu(ixs0),
    .stall_cnt_o(sc0), .flush_cnt_o(fc0)
  );

  pipe_ctrl #(.FLUSH_EXTRA(2)) u_dut_fe2 (
    .clk(clk), .rst(rst),
    .jump_en_i_exu_ctrl(je), .jump_addr_i_exu_ctrl(ja),
    .stall_req_i_exu_ctrl(st), .hazard_i_idu_ctrl(hz),
    .jump_en_o_ctrl_pcu(jen1), .jump_addr_o_ctrl_pcu(adr1),
    .pc_stall_o_ctrl_pcu(pcs1), .ifid_stall_o_ctrl_ifu2idu(ifs1),
    .ifid_flush_o_ctrl_ifu2idu(iff1), .hold_flag_o_ctrl_idu2exu(hld1),
    .idex_stall_o_ctrl_idu2exu(ixs1),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  // Reference: rem[k] = bubble cycles still owed after the last jump
  task automatic model(input int k, output exp_t e);
    e = '0;
    if (rst) begin
      rem[k]   = 0;
      mscnt[k] = 0;
      mfcnt[k] = 0;
      return;
    end
`ifdef CTRL_PERF_CNT_EN
    e.scnt = 16'(mscnt[k]);
    e.fcnt = 16'(mfcnt[k]);
`endif
    if (je) begin
      e.jump_en    = 1'b1;
      e.addr       = ja;
      e.ifid_flush = 1'b1;
      e.hold       = 1'b1;
      rem[k]       = k + 1;
    end else if (st) begin
      e.pc_stall   = 1'b1;
      e.ifid_stall = 1'b1;
      e.idex_stall = 1'b1;
    end else if (hz) begin
      e.pc_stall   = 1'b1;
      e.ifid_stall = 1'b1;
      e.hold       = 1'b1;
    end else if (rem[k] > 0) begin
      e.ifid_flush = 1'b1;
      e.hold       = 1'b1;
      rem[k]       = rem[k] - 1;
    end
    if (e.pc_stall && mscnt[k] < 65535) mscnt[k]++;
    if (e.hold && mfcnt[k] < 65535) mfcnt[k]++;
  endtask

  task automatic step(input logic r, input logic j, input logic [ADDR_W-1:0] a,
                      input logic s, input logic h);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; je = j; ja = a; st = s; hz = h;
    model(0, e); q0.push_back(e);
    model(1, e); q1.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t a, input exp_t e);
    check({tag, "_flags"},
          32'({a.jump_en, a.pc_stall, a.ifid_stall, a.ifid_flush, a.hold, a.idex_stall}),
          32'({e.jump_en, e.pc_stall, e.ifid_stall, e.ifid_flush, e.hold, e.idex_stall}));
    check({tag, "_addr"}, 32'(a.addr), 32'(e.addr));
    check({tag, "_cnts"}, {a.scnt, a.fcnt}, {e.scnt, e.fcnt});
  endtask

  // Monitor: one comparison set per DUT per cycle, one log line per cycle
  always @(negedge clk) begin : monitor
    exp_t e0, e1, a0, a1;
    if (q0.size() > 0 && q1.size() > 0) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      a0 = {jen0, adr0, pcs0, ifs0, iff0, hld0, ixs0, sc0, fc0};
      a1 = {jen1, adr1, pcs1, ifs1, iff1, hld1, ixs1, sc1, fc1};
      compare("fe1", a0, e0);
      compare("fe2", a1, e1);
      $display("[TB] t=%0t in rst=%b je=%b ja=%h st=%b hz=%b | fe1 f=%b a=%h c=%0d/%0d | fe2 f=%b a=%h c=%0d/%0d",
               $time, rst, je, ja, st, hz,
               {jen0, pcs0, ifs0, iff0, hld0, ixs0}, adr0, sc0, fc0,
               {jen1, pcs1, ifs1, iff1, hld1, ixs1}, adr1, sc1, fc1);
    end
  end

  initial begin
    // reset state
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 12'hABC, 1'b1, 1'b1);
    idle(2);
    // single jump, bubble tail
    step(1'b0, 1'b1, 12'h040, 1'b0, 1'b0);
    idle(3);
    // five-cycle EXU stall
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(2);
    // one-cycle load-use hazard
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(1);
    // back-to-back jumps restart the tail
    step(1'b0, 1'b1, 12'h010, 1'b0, 1'b0);
    step(1'b0, 1'b1, 12'h020, 1'b0, 1'b0);
    idle(4);
    // jump beats stall, stall follows
    step(1'b0, 1'b1, 12'h123, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(1);
    // stall in the middle of a tail freezes it
    step(1'b0, 1'b1, 12'h3FF, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(3);
    // reset in the middle of a tail
    step(1'b0, 1'b1, 12'h040, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 18),
           ADDR_W'($urandom),
           ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 20));
    end
    idle(2);
    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
    if (q0.size() > 0 || q1.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain left=%0d expected=0", q0.size() + q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
